// File: rtl/oc8051_psw_ctx.sv
// oc8051_psw_ctx: PSW context save/restore engine.
// Pushes PSW[7:1] on interrupt entry and, on RETI, pops the entry and writes
// it back to the PSW SFR through the SFR write port (parity bit is recomputed
// by the PSW register, so bit 0 is never stored and always written as 0).
// Optional feature macro: OC8051_PSW_CTX_BANKSW_EN -- after each accepted save
// an extra PSW write selects the register bank given on bank_new.
module oc8051_psw_ctx #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [7:0]  PSW_ADDR = 8'hD0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] psw_in,
  input  logic       save,
  input  logic       restore,
  input  logic [1:0] bank_new,
  input  logic       wr_ack,
  input  logic       clr_err,
  output logic       wr,
  output logic       wr_bit,
  output logic [7:0] wr_addr,
  output logic [7:0] data_out,
  output logic       busy,
  output logic [2:0] depth,
  output logic       ovf,
  output logic       unf
);

  localparam int unsigned EW    = 7;  // stored entry width (PSW[7:1])
  localparam int unsigned CW    = 3;  // depth counter width
  localparam int unsigned SLOTS = 8;  // storage slots addressable by the counter

`ifdef OC8051_PSW_CTX_BANKSW_EN
  typedef enum logic [1:0] {S_IDLE, S_POP, S_WRITE, S_BSW} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_POP, S_WRITE} state_e;
`endif

  state_e          state_q;
  logic [EW-1:0]   stack_q [SLOTS];
  logic [EW-1:0]   data_q;
  logic [CW-1:0]   depth_q;
  logic            wr_q;
  logic            pending_q;
  logic            ovf_q;
  logic            unf_q;

  logic            full_c;
  logic            empty_c;
  logic            start_c;
  logic            push_c;
  logic            pop_c;
  logic            ovf_set_c;
  logic            unf_set_c;
  logic [CW-1:0]   pop_idx_c;

  // Event decode: push/pop legality and error conditions for this cycle
  always_comb begin
    full_c    = (depth_q == CW'(DEPTH));
    empty_c   = (depth_q == '0);
    start_c   = (state_q == S_IDLE) && !save && (restore || pending_q);
    push_c    = save && !full_c;
    pop_c     = start_c && !empty_c;
    ovf_set_c = save && full_c;
    unf_set_c = (start_c && empty_c) || (restore && !start_c && pending_q);
    pop_idx_c = depth_q - CW'(1);
  end

  // Context storage; contents are don't-care after reset, so no reset here
  always_ff @(posedge clk) begin
    if (push_c) stack_q[depth_q] <= psw_in[7:1];
  end

  // Control FSM, depth counter, pending restore and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      depth_q   <= '0;
      wr_q      <= 1'b0;
      pending_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      ovf_q <= ovf_set_c || (ovf_q && !clr_err);
      unf_q <= unf_set_c || (unf_q && !clr_err);

      // A started restore consumes one request; a second concurrent one stays queued
      if (start_c) begin
        pending_q <= restore && pending_q && !empty_c;
      end else if (restore && !pending_q) begin
        pending_q <= 1'b1;
      end

      // Pop and push never coincide: a pop requires save to be low
      if (pop_c) begin
        depth_q <= pop_idx_c;
      end else if (push_c) begin
        depth_q <= depth_q + CW'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (pop_c) begin
            state_q <= S_POP;
            data_q  <= stack_q[pop_idx_c];
          end
`ifdef OC8051_PSW_CTX_BANKSW_EN
          else if (push_c) begin
            state_q <= S_BSW;
            wr_q    <= 1'b1;
            data_q  <= {psw_in[7:5], bank_new, psw_in[2:1]};
          end
`endif
        end
        S_POP: begin
          state_q <= S_WRITE;
          wr_q    <= 1'b1;
        end
`ifdef OC8051_PSW_CTX_BANKSW_EN
        S_WRITE, S_BSW: begin
`else
        S_WRITE: begin
`endif
          if (wr_ack) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          wr_q    <= 1'b0;
        end
      endcase
    end
  end

  // Inputs not consumed in every build are folded into a sink
`ifdef OC8051_PSW_CTX_BANKSW_EN
  logic unused_in;
  assign unused_in = psw_in[0];
`else
  logic unused_in;
  assign unused_in = ^{bank_new, psw_in[0]};
`endif

  // Output drive, all derived directly from flops
  assign wr       = wr_q;
  assign wr_bit   = 1'b0;
  assign wr_addr  = wr_q ? PSW_ADDR : 8'h00;
  assign data_out = {data_q, 1'b0};
  assign busy     = (state_q != S_IDLE) || pending_q;
  assign depth    = depth_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;

endmodule

// File: tb/tb_oc8051_psw_ctx.sv
// Directed, table-driven bench for oc8051_psw_ctx (DEPTH=2, PSW_ADDR=8'hD0).
module tb_oc8051_psw_ctx;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clk;
  logic       rst;
  logic [7:0] psw_in;
  logic       save;
  logic       restore;
  logic [1:0] bank_new;
  logic       wr_ack;
  logic       clr_err;
  logic       wr;
  logic       wr_bit;
  logic [7:0] wr_addr;
  logic [7:0] data_out;
  logic       busy;
  logic [2:0] depth;
  logic       ovf;
  logic       unf;

  int checks;
  int passed;

  oc8051_psw_ctx #(.DEPTH(2), .PSW_ADDR(8'hD0)) dut (
    .clk      (clk),
    .rst      (rst),
    .psw_in   (psw_in),
    .save     (save),
    .restore  (restore),
    .bank_new (bank_new),
    .wr_ack   (wr_ack),
    .clr_err  (clr_err),
    .wr       (wr),
    .wr_bit   (wr_bit),
    .wr_addr  (wr_addr),
    .data_out (data_out),
    .busy     (busy),
    .depth    (depth),
    .ovf      (ovf),
    .unf      (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       save;
    logic       restore;
    logic [7:0] psw;
    logic [1:0] bank;
    logic       ack;
    logic       clr;
    logic       e_wr;
    logic [7:0] e_data;
    logic       e_busy;
    logic [2:0] e_depth;
    logic       e_ovf;
    logic       e_unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic s, input logic rs,
                              input logic [7:0] p, input logic [1:0] b,
                              input logic a, input logic c,
                              input logic ew, input logic [7:0] ed,
                              input logic eb, input logic [2:0] edp,
                              input logic eo, input logic eu);
    vec_t v;
    v.rst_n = r;  v.save = s;  v.restore = rs; v.psw = p; v.bank = b;
    v.ack = a;    v.clr = c;
    v.e_wr = ew;  v.e_data = ed; v.e_busy = eb; v.e_depth = edp;
    v.e_ovf = eo; v.e_unf = eu;
    return v;
  endfunction

  // Packed view: {wr, wr_bit, wr_addr, data_out, busy, depth, ovf, unf}
  function automatic logic [23:0] outs();
    return {wr, wr_bit, wr_addr, data_out, busy, depth, ovf, unf};
  endfunction

  function automatic logic [23:0] expect_of(input vec_t v);
    logic [7:0] a;
    a = v.e_wr ? 8'hD0 : 8'h00;
    return {v.e_wr, 1'b0, a, v.e_data, v.e_busy, v.e_depth, v.e_ovf, v.e_unf};
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got wr=%b bit=%b addr=%h data=%h busy=%b depth=%0d ovf=%b unf=%b, expected wr=%b bit=%b addr=%h data=%h busy=%b depth=%0d ovf=%b unf=%b",
               name, act[23], act[22], act[21:14], act[13:6], act[5], act[4:2], act[1], act[0],
               exp[23], exp[22], exp[21:14], exp[13:6], exp[5], exp[4:2], exp[1], exp[0]);
    else
      passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; passed = 0;
    rst = 1'b0; psw_in = 8'h00; save = 1'b0; restore = 1'b0;
    bank_new = 2'b00; wr_ack = 1'b0; clr_err = 1'b0;

`ifdef OC8051_PSW_CTX_BANKSW_EN
    //        rst save rest psw    bank  ack clr | wr data   busy depth  ovf unf
    vecs.push_back(mk(L, L, L, 8'h00, 2'd0, L, L,  L, 8'h00, L, 3'd0, L, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, L, L,  L, 8'h00, L, 3'd0, L, L));
    vecs.push_back(mk(H, H, L, 8'h01, 2'd2, L, L,  H, 8'h10, H, 3'd1, L, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, L, L,  H, 8'h10, H, 3'd1, L, L));
    vecs.push_back(mk(H, L, H, 8'h00, 2'd0, L, L,  H, 8'h10, H, 3'd1, L, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, H, L,  L, 8'h10, H, 3'd1, L, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, H, L,  L, 8'h00, H, 3'd0, L, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, H, L,  H, 8'h00, H, 3'd0, L, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, H, L,  L, 8'h00, L, 3'd0, L, L));
    vecs.push_back(mk(H, H, L, 8'h01, 2'd2, L, L,  H, 8'h10, H, 3'd1, L, L));
`else
    // Reset and single save/restore round trip
    vecs.push_back(mk(L, L, L, 8'h00, 2'd0, L, L,  L, 8'h00, L, 3'd0, L, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, L, L,  L, 8'h00, L, 3'd0, L, L));
    vecs.push_back(mk(H, H, L, 8'hA5, 2'd0, H, L,  L, 8'h00, L, 3'd1, L, L));
    vecs.push_back(mk(H, L, H, 8'h00, 2'd0, H, L,  L, 8'hA4, H, 3'd0, L, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, H, L,  H, 8'hA4, H, 3'd0, L, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, H, L,  L, 8'hA4, L, 3'd0, L, L));
    // LIFO order, second restore arrives while busy
    vecs.push_back(mk(H, H, L, 8'h80, 2'd0, H, L,  L, 8'hA4, L, 3'd1, L, L));
    vecs.push_back(mk(H, H, L, 8'h18, 2'd0, H, L,  L, 8'hA4, L, 3'd2, L, L));
    vecs.push_back(mk(H, L, H, 8'h00, 2'd0, H, L,  L, 8'h18, H, 3'd1, L, L));
    vecs.push_back(mk(H, L, H, 8'h00, 2'd0, H, L,  H, 8'h18, H, 3'd1, L, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, H, L,  L, 8'h18, H, 3'd1, L, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, H, L,  L, 8'h80, H, 3'd0, L, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, H, L,  H, 8'h80, H, 3'd0, L, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, H, L,  L, 8'h80, L, 3'd0, L, L));
    // Overflow: third save dropped, clr_err clears ovf
    vecs.push_back(mk(H, H, L, 8'h02, 2'd0, H, L,  L, 8'h80, L, 3'd1, L, L));
    vecs.push_back(mk(H, H, L, 8'h04, 2'd0, H, L,  L, 8'h80, L, 3'd2, L, L));
    vecs.push_back(mk(H, H, L, 8'hFE, 2'd0, H, L,  L, 8'h80, L, 3'd2, H, L));
    vecs.push_back(mk(H, L, H, 8'h00, 2'd0, H, L,  L, 8'h04, H, 3'd1, H, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, H, L,  H, 8'h04, H, 3'd1, H, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, H, L,  L, 8'h04, L, 3'd1, H, L));
    vecs.push_back(mk(H, L, H, 8'h00, 2'd0, H, L,  L, 8'h02, H, 3'd0, H, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, H, L,  H, 8'h02, H, 3'd0, H, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, H, L,  L, 8'h02, L, 3'd0, H, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, H, H,  L, 8'h02, L, 3'd0, L, L));
    // Underflow; new error beats clr_err in the same cycle
    vecs.push_back(mk(H, L, H, 8'h00, 2'd0, H, L,  L, 8'h02, L, 3'd0, L, H));
    vecs.push_back(mk(H, L, H, 8'h00, 2'd0, H, H,  L, 8'h02, L, 3'd0, L, H));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, H, H,  L, 8'h02, L, 3'd0, L, L));
    // Arbiter stall for 4 cycles with a save during the wait
    vecs.push_back(mk(H, H, L, 8'h33, 2'd0, L, L,  L, 8'h02, L, 3'd1, L, L));
    vecs.push_back(mk(H, L, H, 8'h00, 2'd0, L, L,  L, 8'h32, H, 3'd0, L, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, L, L,  H, 8'h32, H, 3'd0, L, L));
    vecs.push_back(mk(H, H, L, 8'hC0, 2'd0, L, L,  H, 8'h32, H, 3'd1, L, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, L, L,  H, 8'h32, H, 3'd1, L, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, L, L,  H, 8'h32, H, 3'd1, L, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, L, L,  H, 8'h32, H, 3'd1, L, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, H, L,  L, 8'h32, L, 3'd1, L, L));
    // Extra restore while one is already pending sets unf
    vecs.push_back(mk(H, L, H, 8'h00, 2'd0, H, L,  L, 8'hC0, H, 3'd0, L, L));
    vecs.push_back(mk(H, L, H, 8'h00, 2'd0, L, L,  H, 8'hC0, H, 3'd0, L, L));
    vecs.push_back(mk(H, L, H, 8'h00, 2'd0, L, L,  H, 8'hC0, H, 3'd0, L, H));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, H, L,  L, 8'hC0, H, 3'd0, L, H));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, H, L,  L, 8'hC0, L, 3'd0, L, H));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, H, H,  L, 8'hC0, L, 3'd0, L, L));
    // Save and restore together: save first, restore pops the new entry
    vecs.push_back(mk(H, H, H, 8'h5A, 2'd0, H, L,  L, 8'hC0, H, 3'd1, L, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, H, L,  L, 8'h5A, H, 3'd0, L, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, H, L,  H, 8'h5A, H, 3'd0, L, L));
    vecs.push_back(mk(H, L, L, 8'h00, 2'd0, H, L,  L, 8'h5A, L, 3'd0, L, L));
    // Set up a write in flight, with a save during POP, for the reset abort
    vecs.push_back(mk(H, H, L, 8'hFF, 2'd0, L, L,  L, 8'h5A, L, 3'd1, L, L));
    vecs.push_back(mk(H, L, H, 8'h00, 2'd0, L, L,  L, 8'hFE, H, 3'd0, L, L));
    vecs.push_back(mk(H, H, L, 8'h11, 2'd0, L, L,  H, 8'hFE, H, 3'd1, L, L));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst      = vecs[i].rst_n;
      save     = vecs[i].save;
      restore  = vecs[i].restore;
      psw_in   = vecs[i].psw;
      bank_new = vecs[i].bank;
      wr_ack   = vecs[i].ack;
      clr_err  = vecs[i].clr;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), outs(), expect_of(vecs[i]));
    end

    // Reset mid-write: outputs must clear before any clock edge
    @(negedge clk);
    save = 1'b0; restore = 1'b0; psw_in = 8'h00; wr_ack = 1'b0; bank_new = 2'b00;
    #2 rst = 1'b0;
    #1 check("async_rst", outs(), 24'h000000);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check("post_rst_idle", outs(), 24'h000000);

    // Stack really emptied: a restore now underflows without writing
    @(negedge clk);
    restore = 1'b1; wr_ack = 1'b1;
    @(posedge clk);
    #1 check("post_rst_unf", outs(), 24'h000001);
    @(negedge clk);
    restore = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
